// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit, one radix-2 step per cycle
module muldiv_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic [2:0]            funct3_i,
    input  logic [DATA_WIDTH-1:0] operand1_i,
    input  logic [DATA_WIDTH-1:0] operand2_i,
    input  logic                  flush_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [DATA_WIDTH-1:0] result_o
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t        state_q, state_d;
    logic [2:0]    f3_q;
    logic          neg_q, neg_d;
    logic [CW-1:0] cnt_q;
    logic [W-1:0]  a_q, hi_q, lo_q, result_q;

    logic          is_div, s1, s2, n1, n2, div0, ovf, accept, last;
    logic [W-1:0]  abs1, abs2, spec_res;
    logic [W:0]    sum, tmp, diff;
    logic          ge;
    logic [W-1:0]  hi_n, lo_n, qr, qr_s, calc_res;
    logic [2*W-1:0] prod;

    // Operand preparation: signedness per op, absolute values, sign of result, special cases
    always_comb begin
        is_div   = funct3_i[2];
        s1       = is_div ? !funct3_i[0] : (funct3_i != 3'b011);
        s2       = is_div ? !funct3_i[0] : !funct3_i[1];
        n1       = s1 & operand1_i[W-1];
        n2       = s2 & operand2_i[W-1];
        abs1     = n1 ? -operand1_i : operand1_i;
        abs2     = n2 ? -operand2_i : operand2_i;
        neg_d    = (is_div && funct3_i[1]) ? n1 : (n1 ^ n2);
        div0     = is_div && (operand2_i == '0);
        ovf      = is_div && !funct3_i[0] && (operand1_i == {1'b1, {(W-1){1'b0}}})
                   && (operand2_i == '1);
        spec_res = div0 ? (funct3_i[1] ? operand1_i : '1)
                        : (funct3_i[1] ? '0 : {1'b1, {(W-1){1'b0}}});
        accept   = (state_q == IDLE) && start_i && !flush_i;
        last     = (cnt_q == CW'(W - 1));
    end

    // One iteration: shift-add multiply or restoring divide, plus final result select/negate
    always_comb begin
        sum      = {1'b0, hi_q} + {1'b0, lo_q[0] ? a_q : '0};
        tmp      = {hi_q, lo_q[W-1]};
        diff     = tmp - {1'b0, a_q};
        ge       = !diff[W];
        hi_n     = f3_q[2] ? (ge ? diff[W-1:0] : tmp[W-1:0]) : sum[W:1];
        lo_n     = f3_q[2] ? {lo_q[W-2:0], ge} : {sum[0], lo_q[W-1:1]};
        prod     = neg_q ? -{hi_n, lo_n} : {hi_n, lo_n};
        qr       = f3_q[1] ? hi_n : lo_n;
        qr_s     = neg_q ? -qr : qr;
        calc_res = f3_q[2] ? qr_s : ((f3_q[1:0] == 2'b00) ? prod[W-1:0] : prod[2*W-1:W]);
    end

    // Next-state and handshake outputs; flush always wins
    always_comb begin
        state_d = state_q;
        busy_o  = 1'b0;
        done_o  = 1'b0;
        case (state_q)
            IDLE: if (accept) begin
                busy_o  = rst_n;
                state_d = (div0 || ovf) ? DONE : CALC;
            end
            CALC: begin
                busy_o  = 1'b1;
                state_d = last ? DONE : CALC;
            end
            DONE: begin
                done_o  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (flush_i) state_d = IDLE;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Datapath: latch prepared operands on accept, iterate in CALC, capture result entering DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f3_q     <= '0;
            neg_q    <= 1'b0;
            cnt_q    <= '0;
            a_q      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            result_q <= '0;
        end else begin
            if (accept) begin
                f3_q  <= funct3_i;
                neg_q <= neg_d;
                cnt_q <= '0;
                a_q   <= is_div ? abs2 : abs1;
                hi_q  <= '0;
                lo_q  <= is_div ? abs1 : abs2;
                if (div0 || ovf) result_q <= spec_res;
            end else if (state_q == CALC && !flush_i) begin
                hi_q  <= hi_n;
                lo_q  <= lo_n;
                cnt_q <= cnt_q + 1'b1;
                if (last) result_q <= calc_res;
            end
            if (flush_i) cnt_q <= '0;
        end
    end

    assign result_o = result_q;
endmodule
